// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: state encoding and default sizing shared by the FIFO write arbiter
package fifo_arb_pkg;
   typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;
   localparam int N_REQ_DEF     = 4;
   localparam int WIDTH_DEF     = 8;
   localparam int MAX_BURST_DEF = 4;
endpackage

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// rr_picker: combinational search for the first set request at or after rr_ptr, circularly
module rr_picker #(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] rr_ptr_i,
   output logic          found_o,
   output logic [IW-1:0] index_o
);
   // walk offsets from farthest to nearest so the match closest to rr_ptr is the last one written
   always_comb begin
      found_o = 1'b0;
      index_o = '0;
      for (int k = N - 1; k >= 0; k--) begin
         if (req_i[rr_ptr_i + IW'(k)]) begin
            found_o = 1'b1;
            index_o = rr_ptr_i + IW'(k);
         end
      end
   end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin, burst-limited sharing of one FIFO write port among N_REQ requesters
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int N_REQ     = N_REQ_DEF,
   parameter int WIDTH     = WIDTH_DEF,
   parameter int MAX_BURST = MAX_BURST_DEF
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [N_REQ-1:0]         req_valid,
   input  logic [N_REQ*WIDTH-1:0]   req_data,
   output logic [N_REQ-1:0]         req_ready,
   input  logic                     fifo_full,
   output logic                     fifo_wr_en,
   output logic [WIDTH-1:0]         fifo_din,
   output logic [$clog2(N_REQ)-1:0] grant_id,
   output logic                     busy,
   output logic [15:0]              word_cnt
);
   localparam int IW = $clog2(N_REQ);
   localparam int BW = $clog2(MAX_BURST + 1);

   state_t        state_q, state_d;
   logic [IW-1:0] rr_ptr_q, rr_ptr_d, grant_q, grant_d, pick_idx;
   logic [BW-1:0] beat_q, beat_d;
   logic [15:0]   word_q, word_d;
   logic          pick_found;

   rr_picker #(.N(N_REQ)) u_pick (
      .req_i    (req_valid),
      .rr_ptr_i (rr_ptr_q),
      .found_o  (pick_found),
      .index_o  (pick_idx)
   );

   // state and counters; reset aborts any burst and restarts priority at requester 0
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         rr_ptr_q <= '0;
         grant_q  <= '0;
         beat_q   <= '0;
         word_q   <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         grant_q  <= grant_d;
         beat_q   <= beat_d;
         word_q   <= word_d;
      end
   end

   // grant on any valid in IDLE; leave BURST on a dropped valid or on the last allowed word
   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      grant_d  = grant_q;
      beat_d   = fifo_wr_en ? beat_q + BW'(1) : beat_q;
      word_d   = fifo_wr_en ? word_q + 16'd1 : word_q;
      if (state_q == IDLE) begin
         if (pick_found) begin
            state_d = BURST;
            grant_d = pick_idx;
            beat_d  = '0;
         end
      end else if (!req_valid[grant_q] || (fifo_wr_en && beat_q == BW'(MAX_BURST - 1))) begin
         state_d  = IDLE;
         rr_ptr_d = grant_q + IW'(1);
      end
   end

   // only the grant holder sees ready; fullness stalls the holder without revoking its grant
   always_comb begin
      busy               = state_q == BURST;
      req_ready          = '0;
      req_ready[grant_q] = busy && !fifo_full;
      fifo_wr_en         = busy && req_valid[grant_q] && !fifo_full;
      fifo_din           = busy ? req_data[grant_q*WIDTH +: WIDTH] : '0;
      grant_id           = grant_q;
      word_cnt           = word_q;
   end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed scenarios plus randomized traffic against a behavioural model
module tb_fifo_wr_arbiter;
   localparam int N  = 4;
   localparam int W  = 8;
   localparam int MB = 4;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   req_valid, req_ready;
   logic [N*W-1:0] req_data;
   logic           fifo_full, fifo_wr_en, busy;
   logic [W-1:0]   fifo_din;
   logic [1:0]     grant_id;
   logic [15:0]    word_cnt;

   int errors = 0;
   int checks = 0;

   bit m_busy;
   int m_gid, m_prio, m_beats, m_words;
   logic           e_busy, e_wr;
   logic [1:0]     e_gid;
   logic [N-1:0]   e_ready;
   logic [W-1:0]   e_din;
   logic [15:0]    e_words;

   fifo_wr_arbiter #(.N_REQ(N), .WIDTH(W), .MAX_BURST(MB)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_data   (req_data),
      .req_ready  (req_ready),
      .fifo_full  (fifo_full),
      .fifo_wr_en (fifo_wr_en),
      .fifo_din   (fifo_din),
      .grant_id   (grant_id),
      .busy       (busy),
      .word_cnt   (word_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #1500000;
      $display("FAIL watchdog: simulation time exhausted, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

   task automatic mdl_reset();
      m_busy  = 1'b0;
      m_gid   = 0;
      m_prio  = 0;
      m_beats = 0;
      m_words = 0;
   endtask

   task automatic mdl_expect();
      if (rst) mdl_reset();
      e_busy  = m_busy;
      e_gid   = 2'(m_gid);
      e_words = 16'(m_words);
      e_ready = '0;
      if (m_busy && !fifo_full) e_ready[m_gid] = 1'b1;
      e_wr    = m_busy && req_valid[m_gid] && !fifo_full;
      e_din   = m_busy ? req_data[m_gid*W +: W] : '0;
   endtask

   task automatic mdl_next();
      if (rst) mdl_reset();
      else if (!m_busy) begin
         for (int k = 0; k < N; k++) begin
            if (!m_busy && req_valid[(m_prio + k) % N]) begin
               m_gid   = (m_prio + k) % N;
               m_busy  = 1'b1;
               m_beats = 0;
            end
         end
      end else if (!req_valid[m_gid]) begin
         m_busy = 1'b0;
         m_prio = (m_gid + 1) % N;
      end else if (!fifo_full) begin
         m_words = (m_words + 1) % 65536;
         m_beats++;
         if (m_beats == MB) begin
            m_busy = 1'b0;
            m_prio = (m_gid + 1) % N;
         end
      end
   endtask

   task automatic settle();
      #4;
      mdl_expect();
   endtask

   task automatic tick();
      mdl_next();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      req_valid = '0;
      fifo_full = 1'b0;
      settle();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      req_valid = '1;
      req_data  = $urandom;
      fifo_full = 1'b0;
      for (int i = 0; i < 2; i++) begin
         settle();
         checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
         checks++; if (req_ready !== '0) begin errors++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
         checks++; if (fifo_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b want 0", fifo_wr_en); end
         checks++; if (fifo_din !== '0) begin errors++; $display("FAIL reset_din: got %h want 00", fifo_din); end
         checks++; if (word_cnt !== 16'd0) begin errors++; $display("FAIL reset_word_cnt: got %0d want 0", word_cnt); end
         checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL reset_grant: got %0d want 0", grant_id); end
         tick();
      end
      rst = 1'b0;
   endtask

   task automatic test_single();
      do_reset();
      req_valid = 4'b0100;
      req_data  = 32'h00A5_0000;
      settle();
      checks++; if ({busy, fifo_wr_en} !== 2'b00) begin errors++; $display("FAIL single_arb_cycle: got busy/wr=%b want 00", {busy, fifo_wr_en}); end
      tick();
      for (int i = 0; i < 4; i++) begin
         settle();
         checks++; if ({busy, grant_id, fifo_wr_en, fifo_din} !== {1'b1, 2'd2, 1'b1, 8'hA5}) begin
            errors++; $display("FAIL single_word%0d: got busy=%b gid=%0d wr=%b din=%h want 1 2 1 a5", i, busy, grant_id, fifo_wr_en, fifo_din);
         end
         tick();
      end
      req_valid = 4'b1111;
      settle();
      checks++; if ({busy, word_cnt} !== {1'b0, 16'd4}) begin errors++; $display("FAIL single_done: got busy=%b cnt=%0d want 0 4", busy, word_cnt); end
      tick();
      settle();
      checks++; if ({busy, grant_id} !== {1'b1, 2'd3}) begin errors++; $display("FAIL single_rr_ptr: got busy=%b gid=%0d want 1 3", busy, grant_id); end
      req_valid = '0;
      tick();
      tick();
   endtask

   task automatic test_all_valid();
      logic         xb;
      logic [1:0]   xg;
      logic [N-1:0] xr;
      logic [W-1:0] xd;
      do_reset();
      req_valid = '1;
      for (int c = 0; c < 25; c++) begin
         req_data = $urandom;
         settle();
         xb = (c % 5) != 0;
         xg = 2'(((c - 1) / 5) % 4);
         xr = '0;
         if (xb) xr[xg] = 1'b1;
         xd = xb ? req_data[xg*W +: W] : '0;
         checks++; if ({busy, grant_id, req_ready, fifo_wr_en, fifo_din} !== {xb, xg, xr, xb, xd}) begin
            errors++; $display("FAIL all_valid_c%0d: got busy=%b gid=%0d rdy=%b wr=%b din=%h want %b %0d %b %b %h", c, busy, grant_id, req_ready, fifo_wr_en, fifo_din, xb, xg, xr, xb, xd);
         end
         tick();
      end
      settle();
      checks++; if (word_cnt !== 16'd20) begin errors++; $display("FAIL all_valid_count: got %0d want 20", word_cnt); end
      tick();
   endtask

   task automatic test_full_stall();
      do_reset();
      req_valid = 4'b0010;
      req_data  = $urandom;
      settle();
      tick();
      settle();
      checks++; if ({busy, grant_id, req_ready, fifo_wr_en} !== {1'b1, 2'd1, 4'b0010, 1'b1}) begin errors++; $display("FAIL stall_first: got busy=%b gid=%0d rdy=%b wr=%b want 1 1 0010 1", busy, grant_id, req_ready, fifo_wr_en); end
      tick();
      fifo_full = 1'b1;
      for (int i = 0; i < 3; i++) begin
         settle();
         checks++; if ({busy, grant_id, req_ready, fifo_wr_en} !== {1'b1, 2'd1, 4'b0000, 1'b0}) begin errors++; $display("FAIL stall_full%0d: got busy=%b gid=%0d rdy=%b wr=%b want 1 1 0000 0", i, busy, grant_id, req_ready, fifo_wr_en); end
         tick();
      end
      fifo_full = 1'b0;
      for (int i = 0; i < 3; i++) begin
         settle();
         checks++; if ({req_ready, fifo_wr_en} !== {4'b0010, 1'b1}) begin errors++; $display("FAIL stall_resume%0d: got rdy=%b wr=%b want 0010 1", i, req_ready, fifo_wr_en); end
         tick();
      end
      settle();
      checks++; if ({busy, word_cnt} !== {1'b0, 16'd4}) begin errors++; $display("FAIL stall_done: got busy=%b cnt=%0d want 0 4", busy, word_cnt); end
      req_valid = '0;
      tick();
   endtask

   task automatic test_drop();
      do_reset();
      req_valid = 4'b0011;
      req_data  = $urandom;
      settle();
      tick();
      for (int i = 0; i < 2; i++) begin
         settle();
         checks++; if ({grant_id, fifo_wr_en} !== {2'd0, 1'b1}) begin errors++; $display("FAIL drop_word%0d: got gid=%0d wr=%b want 0 1", i, grant_id, fifo_wr_en); end
         tick();
      end
      req_valid = 4'b0010;
      settle();
      checks++; if ({busy, fifo_wr_en} !== 2'b10) begin errors++; $display("FAIL drop_exit: got busy/wr=%b want 10", {busy, fifo_wr_en}); end
      tick();
      req_valid = 4'b0011;
      settle();
      checks++; if ({busy, word_cnt} !== {1'b0, 16'd2}) begin errors++; $display("FAIL drop_idle: got busy=%b cnt=%0d want 0 2", busy, word_cnt); end
      tick();
      settle();
      checks++; if ({busy, grant_id} !== {1'b1, 2'd1}) begin errors++; $display("FAIL drop_next_grant: got busy=%b gid=%0d want 1 1", busy, grant_id); end
      req_valid = '0;
      tick();
      tick();
   endtask

   task automatic test_reset_mid();
      do_reset();
      req_valid = 4'b1100;
      req_data  = $urandom;
      settle();
      tick();
      for (int i = 0; i < 2; i++) begin
         settle();
         tick();
      end
      settle();
      checks++; if ({grant_id, fifo_wr_en} !== {2'd2, 1'b1}) begin errors++; $display("FAIL rstmid_third: got gid=%0d wr=%b want 2 1", grant_id, fifo_wr_en); end
      #1 rst = 1'b1;
      #1;
      checks++; if ({busy, req_ready, fifo_wr_en, fifo_din, word_cnt, grant_id} !== '0) begin
         errors++; $display("FAIL rstmid_immediate: got busy=%b rdy=%b wr=%b din=%h cnt=%0d gid=%0d want all 0", busy, req_ready, fifo_wr_en, fifo_din, word_cnt, grant_id);
      end
      tick();
      rst       = 1'b0;
      req_valid = 4'b1110;
      settle();
      checks++; if ({busy, fifo_wr_en} !== 2'b00) begin errors++; $display("FAIL rstmid_idle: got busy/wr=%b want 00", {busy, fifo_wr_en}); end
      tick();
      settle();
      checks++; if ({busy, grant_id} !== {1'b1, 2'd1}) begin errors++; $display("FAIL rstmid_regrant: got busy=%b gid=%0d want 1 1", busy, grant_id); end
      req_valid = '0;
      tick();
      tick();
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 800; c++) begin
         for (int i = 0; i < N; i++) req_valid[i] = $urandom_range(3) != 0;
         req_data  = $urandom;
         fifo_full = $urandom_range(3) == 0;
         rst       = $urandom_range(99) == 0;
         settle();
         checks++; if ({busy, grant_id, req_ready, fifo_wr_en, fifo_din, word_cnt} !== {e_busy, e_gid, e_ready, e_wr, e_din, e_words}) begin
            errors++; $display("FAIL random_c%0d: got busy=%b gid=%0d rdy=%b wr=%b din=%h cnt=%0d want %b %0d %b %b %h %0d", c, busy, grant_id, req_ready, fifo_wr_en, fifo_din, word_cnt, e_busy, e_gid, e_ready, e_wr, e_din, e_words);
         end
         tick();
      end
      rst = 1'b0;
   endtask

   task automatic test_wrap();
      int  wr_n = 0;
      bit  seen0 = 1'b0;
      do_reset();
      req_valid = '1;
      for (int c = 0; c < 90000 && wr_n < 65537; c++) begin
         req_data = $urandom;
         settle();
         if (fifo_wr_en) wr_n++;
         tick();
         if (wr_n == 65536 && !seen0) begin
            seen0 = 1'b1;
            checks++; if (word_cnt !== 16'd0) begin errors++; $display("FAIL wrap_65536: got %0d want 0", word_cnt); end
         end
      end
      checks++; if (wr_n != 65537) begin errors++; $display("FAIL wrap_timeout: got %0d writes want 65537", wr_n); end
      checks++; if (word_cnt !== 16'd1) begin errors++; $display("FAIL wrap_65537: got %0d want 1", word_cnt); end
      req_valid = '0;
      tick();
   endtask

   initial begin
      rst       = 1'b1;
      req_valid = '0;
      req_data  = '0;
      fifo_full = 1'b0;
      mdl_reset();
      test_reset();
      test_single();
      test_all_valid();
      test_full_stall();
      test_drop();
      test_reset_mid();
      test_random();
      test_wrap();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
